// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants, fetch FSM states and queue entry layout for the instruction-fetch unit.
package proc_fetch_pkg;

  localparam int DBITS          = 32;
  localparam int INST_BIT_WIDTH = 32;
  localparam logic [DBITS-1:0] INST_SIZE = 32'd4;
  localparam logic [DBITS-1:0] START_PC  = 32'h40;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DBITS-1:0]          pc;
    logic [INST_BIT_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Memory-side and decode-side signal bundle of the fetch unit.
// Decode handshake: the head transfers on a rising edge where out_valid && out_ready.
interface inst_fetch_unit_if;

  logic [proc_fetch_pkg::DBITS-1:0]          pcOut;
  logic [proc_fetch_pkg::INST_BIT_WIDTH-1:0] instWord;
  logic                                      redirect_valid;
  logic [proc_fetch_pkg::DBITS-1:0]          redirect_pc;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [proc_fetch_pkg::INST_BIT_WIDTH-1:0] out_inst;
  logic [proc_fetch_pkg::DBITS-1:0]          out_pc;
  logic [proc_fetch_pkg::DBITS-1:0]          out_pc_next;

  modport master (
    output pcOut, out_valid, out_inst, out_pc, out_pc_next,
    input  instWord, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  pcOut, out_valid, out_inst, out_pc, out_pc_next,
    output instWord, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/inst_fetch_unit_queue.sv
// Small synchronous FIFO of {pc, inst} fetch entries; flush empties it in one edge.
module fetch_queue
  import proc_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq,
  input  fetch_entry_t  enq_data,
  input  logic          deq,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Flush wins over any enqueue/dequeue in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q] = enq_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch initiator: BOOT/RUN/STALL PC sequencer feeding a fetch queue toward decode.
// Optional FETCH_PERF_CNT_EN adds fetch_count, stall_cycles and flush_count outputs.
module inst_fetch_unit
  import proc_fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic               CLOCK_50,
  input  logic               FPGA_RESET_N,
  inst_fetch_unit_if.master  fif,
  output fetch_state_e       state_dbg
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [DBITS-1:0] fetch_pc_q, fetch_pc_d;
  logic             enq, deq;
  logic             q_full, q_empty;
  logic [CW-1:0]    q_count;
  fetch_entry_t     q_head, enq_entry;

  assign enq_entry = '{pc: fetch_pc_q, inst: fif.instWord};

  // Redirect overrides the sequencer; an enqueue is allowed into a full queue only when its head leaves.
  always_comb begin
    deq        = !q_empty && fif.out_ready;
    enq        = 1'b0;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (fif.redirect_valid) begin
      state_d    = RUN;
      fetch_pc_d = {fif.redirect_pc[DBITS-1:2], 2'b00};
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (!q_full || deq) begin
            enq        = 1'b1;
            fetch_pc_d = fetch_pc_q + INST_SIZE;
            if (!deq && q_count == CW'(QUEUE_DEPTH - 1)) state_d = STALL;
          end else begin
            state_d = STALL;
          end
        end
        STALL: begin
          if (deq) begin
            enq        = 1'b1;
            fetch_pc_d = fetch_pc_q + INST_SIZE;
            state_d    = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!FPGA_RESET_N) begin
      state_q    <= BOOT;
      fetch_pc_q <= START_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk      (CLOCK_50),
    .rst_n    (FPGA_RESET_N),
    .enq      (enq),
    .enq_data (enq_entry),
    .deq      (deq),
    .flush    (fif.redirect_valid),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count),
    .head     (q_head)
  );

  assign fif.pcOut       = fetch_pc_q;
  assign fif.out_valid   = !q_empty;
  assign fif.out_inst    = q_head.inst;
  assign fif.out_pc      = q_head.pc;
  assign fif.out_pc_next = q_empty ? '0 : q_head.pc + INST_SIZE;
  assign state_dbg       = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        discards;

  // A head consumed in the redirect cycle is not a discarded entry.
  always_comb begin
    discards    = deq ? (q_count > CW'(1)) : (q_count != '0);
    fetch_cnt_d = fetch_cnt_q + 32'(enq);
    stall_cnt_d = stall_cnt_q + 32'(state_q == STALL);
    flush_cnt_d = flush_cnt_q + 32'(fif.redirect_valid && discards);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!FPGA_RESET_N) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: boot, backpressure, redirect, redirect+dequeue, wrap and mid-run reset.
module tb_inst_fetch_unit;
  import proc_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  inst_fetch_unit_if ifc ();
  fetch_state_e state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_cycles, flush_count;
`endif

  inst_fetch_unit #(.QUEUE_DEPTH(2)) dut (
    .CLOCK_50     (clk),
    .FPGA_RESET_N (rst_n),
    .fif          (ifc.master),
    .state_dbg    (state_dbg)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  // Instruction memory model: a few fixed words, otherwise a pattern derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h2f000000;
      32'h44:  return 32'hfbf00001;
      32'h5C:  return 32'hc0ffff00;
      default: return {~a[15:0], a[15:0]};
    endcase
  endfunction

  assign ifc.instWord = mem_word(ifc.pcOut);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ifc.out_ready = 1'b1; ifc.redirect_valid = 1'b0; ifc.redirect_pc = '0;
    tick(); tick();
    vectors++; if (ifc.pcOut !== 32'h40) begin miscompares++; $display("FAIL reset_pcOut got %h exp %h", ifc.pcOut, 32'h40); end
    vectors++; if (ifc.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", ifc.out_valid); end
    vectors++; if (ifc.out_inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst got %h exp 0", ifc.out_inst); end
    vectors++; if (ifc.out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc got %h exp 0", ifc.out_pc); end
    vectors++; if (ifc.out_pc_next !== 32'h0) begin miscompares++; $display("FAIL reset_pc_next got %h exp 0", ifc.out_pc_next); end
    vectors++; if (state_dbg !== BOOT) begin miscompares++; $display("FAIL reset_state got %0d exp %0d", state_dbg, BOOT); end
    rst_n = 1'b1;
    tick();
    vectors++; if (ifc.pcOut !== 32'h40) begin miscompares++; $display("FAIL boot_pcOut got %h exp %h", ifc.pcOut, 32'h40); end
    vectors++; if (ifc.out_valid !== 1'b0) begin miscompares++; $display("FAIL boot_valid got %b exp 0", ifc.out_valid); end
    tick();
    vectors++; if (ifc.out_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid got %b exp 1", ifc.out_valid); end
    vectors++; if (ifc.out_inst !== 32'h2f000000) begin miscompares++; $display("FAIL first_inst got %h exp %h", ifc.out_inst, 32'h2f000000); end
    vectors++; if (ifc.out_pc !== 32'h40) begin miscompares++; $display("FAIL first_pc got %h exp %h", ifc.out_pc, 32'h40); end
    vectors++; if (ifc.out_pc_next !== 32'h44) begin miscompares++; $display("FAIL first_pc_next got %h exp %h", ifc.out_pc_next, 32'h44); end
    tick();
    vectors++; if (ifc.out_inst !== 32'hfbf00001) begin miscompares++; $display("FAIL second_inst got %h exp %h", ifc.out_inst, 32'hfbf00001); end
    vectors++; if (ifc.out_pc !== 32'h44) begin miscompares++; $display("FAIL second_pc got %h exp %h", ifc.out_pc, 32'h44); end
  endtask

  task automatic test_backpressure();
    rst_n = 1'b0; ifc.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (fetch_count !== 32'd0 || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin miscompares++; $display("FAIL perf_reset got %0d/%0d/%0d exp 0/0/0", fetch_count, stall_cycles, flush_count); end
`endif
    tick(); tick(); tick();
    vectors++; if (state_dbg !== STALL) begin miscompares++; $display("FAIL bp_state got %0d exp %0d", state_dbg, STALL); end
    vectors++; if (ifc.pcOut !== 32'h48) begin miscompares++; $display("FAIL bp_pcOut got %h exp %h", ifc.pcOut, 32'h48); end
    vectors++; if (ifc.out_pc !== 32'h40 || ifc.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_head got %h/%b exp 40/1", ifc.out_pc, ifc.out_valid); end
    tick();
    vectors++; if (ifc.pcOut !== 32'h48 || state_dbg !== STALL) begin miscompares++; $display("FAIL bp_hold got %h/%0d exp 48/%0d", ifc.pcOut, state_dbg, STALL); end
    ifc.out_ready = 1'b1;
    tick();
    vectors++; if (ifc.out_pc !== 32'h44) begin miscompares++; $display("FAIL drain1_pc got %h exp %h", ifc.out_pc, 32'h44); end
    vectors++; if (ifc.pcOut !== 32'h4C || state_dbg !== RUN) begin miscompares++; $display("FAIL drain1_fetch got %h/%0d exp 4c/%0d", ifc.pcOut, state_dbg, RUN); end
    tick();
    vectors++; if (ifc.out_pc !== 32'h48 || ifc.out_inst !== 32'hffb70048) begin miscompares++; $display("FAIL drain2 got %h/%h exp 48/ffb70048", ifc.out_pc, ifc.out_inst); end
    tick();
    vectors++; if (ifc.out_pc !== 32'h4C) begin miscompares++; $display("FAIL drain3_pc got %h exp %h", ifc.out_pc, 32'h4C); end
  endtask

  task automatic test_redirect();
    ifc.out_ready = 1'b0; ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h5E;
    tick();
    ifc.redirect_valid = 1'b0; ifc.out_ready = 1'b1;
    vectors++; if (ifc.out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush got %b exp 0", ifc.out_valid); end
    vectors++; if (ifc.pcOut !== 32'h5C) begin miscompares++; $display("FAIL redir_pcOut got %h exp %h", ifc.pcOut, 32'h5C); end
    tick();
    vectors++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h5C) begin miscompares++; $display("FAIL redir_head got %b/%h exp 1/5c", ifc.out_valid, ifc.out_pc); end
    vectors++; if (ifc.out_inst !== 32'hc0ffff00) begin miscompares++; $display("FAIL redir_inst got %h exp %h", ifc.out_inst, 32'hc0ffff00); end
    vectors++; if (ifc.pcOut !== 32'h60) begin miscompares++; $display("FAIL redir_next_fetch got %h exp %h", ifc.pcOut, 32'h60); end
    tick();
    vectors++; if (ifc.out_pc !== 32'h60 || ifc.out_valid !== 1'b1) begin miscompares++; $display("FAIL redir_follow got %h/%b exp 60/1", ifc.out_pc, ifc.out_valid); end
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (fetch_count !== 32'd7) begin miscompares++; $display("FAIL perf_fetch got %0d exp 7", fetch_count); end
    vectors++; if (stall_cycles !== 32'd2) begin miscompares++; $display("FAIL perf_stall got %0d exp 2", stall_cycles); end
    vectors++; if (flush_count !== 32'd1) begin miscompares++; $display("FAIL perf_flush got %0d exp 1", flush_count); end
`endif
  endtask

  task automatic test_redirect_deq();
    ifc.out_ready = 1'b1; ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h40;
    tick();
    ifc.redirect_valid = 1'b0;
    vectors++; if (ifc.out_valid !== 1'b0) begin miscompares++; $display("FAIL rdq_empty got %b exp 0", ifc.out_valid); end
    vectors++; if (ifc.pcOut !== 32'h40) begin miscompares++; $display("FAIL rdq_pcOut got %h exp %h", ifc.pcOut, 32'h40); end
    tick();
    vectors++; if (ifc.out_pc !== 32'h40 || ifc.out_inst !== 32'h2f000000) begin miscompares++; $display("FAIL rdq_head got %h/%h exp 40/2f000000", ifc.out_pc, ifc.out_inst); end
    tick();
    vectors++; if (ifc.out_pc !== 32'h44 || ifc.out_inst !== 32'hfbf00001) begin miscompares++; $display("FAIL rdq_seq got %h/%h exp 44/fbf00001", ifc.out_pc, ifc.out_inst); end
  endtask

  task automatic test_wrap_reset();
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'hFFFFFFFC;
    tick();
    ifc.redirect_valid = 1'b0;
    tick();
    vectors++; if (ifc.out_pc !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL wrap_pc got %h exp fffffffc", ifc.out_pc); end
    vectors++; if (ifc.out_pc_next !== 32'h0) begin miscompares++; $display("FAIL wrap_pc_next got %h exp 0", ifc.out_pc_next); end
    vectors++; if (ifc.pcOut !== 32'h0) begin miscompares++; $display("FAIL wrap_pcOut got %h exp 0", ifc.pcOut); end
    tick();
    vectors++; if (ifc.out_pc !== 32'h0 || ifc.out_inst !== 32'hffff0000) begin miscompares++; $display("FAIL wrap_zero got %h/%h exp 0/ffff0000", ifc.out_pc, ifc.out_inst); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++; if (ifc.pcOut !== 32'h40) begin miscompares++; $display("FAIL midrst_pcOut got %h exp %h", ifc.pcOut, 32'h40); end
    vectors++; if (ifc.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b exp 0", ifc.out_valid); end
    vectors++; if (state_dbg !== BOOT) begin miscompares++; $display("FAIL midrst_state got %0d exp %0d", state_dbg, BOOT); end
    tick(); tick();
    vectors++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h40) begin miscompares++; $display("FAIL reboot_head got %b/%h exp 1/40", ifc.out_valid, ifc.out_pc); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_redirect_deq();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
